// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller driving the IF/ID and ID/EX latch
// enables/flushes and the PC write enable.
//  - Load-use hazard: one bubble into ID/EX while PC and IF/ID hold.
//  - MUL/DIV: after issue, the front end holds for MD_LAT-1 cycles (MD_WAIT).
//  - Taken branch/jump resolved in EX: squash IF/ID and ID/EX.
// Optional feature macro: HAZARD_PERF_EN enables saturating stall/flush
// counters; when undefined, stall_cnt and flush_cnt are tied to zero.
//
// Ports:
//  clk, rst                    clock (rising edge), synchronous active-high reset
//  id_rs1, id_rs2              source registers of the ID instruction
//  id_use_rs1, id_use_rs2      ID instruction reads rs1 / rs2
//  id_md_op                    ID instruction is MUL/DIV
//  ex_rd, ex_mem_read          destination reg / is-load of the EX instruction
//  ex_branch_taken             EX resolved a taken branch/jump
//  pc_en                       PC write enable
//  if_id_en, if_id_flush       IF/ID latch enable / load NOP
//  id_ex_en, id_ex_flush       ID/EX latch enable / load bubble
//  md_busy                     high while waiting on MUL/DIV
//  stall_cnt, flush_cnt        perf counters
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_md_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned MdCntW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  // Issue cycle itself counts as one of the MD_LAT EX cycles, and the
  // counter value 0 is one more wait cycle, hence MD_LAT-2.
  localparam logic [MdCntW-1:0] MdInit = MdCntW'(MD_LAT - 2);

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  state_e              state_q, state_d;
  logic [MdCntW-1:0]   md_cnt_q, md_cnt_d;
  logic                lu;

  // Register 0 is hard-wired zero and can never be a real dependency.
  always_comb begin
    lu = ex_mem_read && (ex_rd != '0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    md_busy     = 1'b0;
    // While rst is high the outputs stay at the plain-advance values.
    if (!rst) begin
      case (state_q)
        StRun: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_md_op) begin
            state_d  = StMdWait;
            md_cnt_d = MdInit;
          end
        end
        StMdWait: begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          md_busy  = 1'b1;
          if (md_cnt_q == '0) begin
            state_d = StRun;
          end else begin
            md_cnt_d = md_cnt_q - 1'b1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (if_id_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, id_md_op, ex_mem_read, ex_branch_taken;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, md_busy;
  logic [31:0] stall_cnt, flush_cnt;
  logic [5:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_md_op(id_md_op), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .md_busy(md_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, md_busy}
  assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, md_busy};

  localparam logic [5:0] ONorm  = 6'b110100;
  localparam logic [5:0] OLu    = 6'b000110;
  localparam logic [5:0] OFlush = 6'b111110;
  localparam logic [5:0] OMd    = 6'b000001;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       md;
    logic [4:0] rd;
    logic       mr;
    logic       bt;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_md_op = 0;
    ex_mem_read = 0; ex_branch_taken = 0;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    id_md_op = v.md; ex_rd = v.rd; ex_mem_read = v.mr; ex_branch_taken = v.bt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //            rs1    rs2    u1 u2 md rd     mr bt exp
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, ONorm};   // idle
    vecs[1]  = '{5'd0, 5'd5, 0, 1, 0, 5'd5, 1, 0, OLu};     // load-use on rs2
    vecs[2]  = '{5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 0, ONorm};   // rd=0 never hazards
    vecs[3]  = '{5'd7, 5'd0, 0, 0, 0, 5'd7, 1, 0, ONorm};   // rs1 not read
    vecs[4]  = '{5'd9, 5'd3, 1, 1, 0, 5'd9, 1, 0, OLu};     // load-use on rs1
    vecs[5]  = '{5'd9, 5'd0, 1, 0, 0, 5'd9, 0, 0, ONorm};   // not a load
    vecs[6]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, OFlush};  // taken branch
    vecs[7]  = '{5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 1, OFlush};  // branch beats lu+md
    vecs[8]  = '{5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0, OLu};     // lu beats md
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, ONorm};   // still in RUN
    vecs[10] = '{5'd2, 5'd6, 1, 0, 0, 5'd6, 1, 0, ONorm};   // rs2 match, unused

    idle();
    rst = 1'b1;
    @(negedge clk);
    ex_branch_taken = 1'b1;   // ignored while in reset
    #1 check("rst_outs", {26'd0, outs}, {26'd0, ONorm});
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1 check("post_rst_outs", {26'd0, outs}, {26'd0, ONorm});
    check("post_rst_stall_cnt", stall_cnt, 32'd0);
    check("post_rst_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);

    // Single-cycle vectors, all leaving the FSM in RUN.
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i]);
      #1 check($sformatf("vec%0d", i), {26'd0, outs}, {26'd0, vecs[i].exp});
      @(negedge clk);
    end
    idle();
    #1 check("tbl_stall_cnt", stall_cnt, PerfEn ? 32'd3 : 32'd0);
    check("tbl_flush_cnt", flush_cnt, PerfEn ? 32'd2 : 32'd0);

    // Load-use then normal advance next cycle.
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    #1 check("lu_stall", {26'd0, outs}, {26'd0, OLu});
    @(negedge clk);
    ex_mem_read = 0;
    #1 check("lu_after", {26'd0, outs}, {26'd0, ONorm});
    @(negedge clk);

    // MUL/DIV: exactly 3 wait cycles, branch/lu ignored meanwhile.
    do_reset();
    idle();
    id_md_op = 1'b1;
    #1 check("md_issue", {26'd0, outs}, {26'd0, ONorm});
    @(negedge clk);
    idle();
    ex_branch_taken = 1'b1;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("md_wait%0d", c), {26'd0, outs}, {26'd0, OMd});
      @(negedge clk);
    end
    idle();
    #1 check("md_done", {26'd0, outs}, {26'd0, ONorm});
    check("md_stall_cnt", stall_cnt, PerfEn ? 32'd3 : 32'd0);
    check("md_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);

    // Branch alone bumps flush_cnt by one.
    ex_branch_taken = 1'b1;
    @(negedge clk);
    idle();
    #1 check("br_flush_cnt", flush_cnt, PerfEn ? 32'd1 : 32'd0);

    // Reset during the 2nd MD_WAIT cycle.
    id_md_op = 1'b1;
    @(negedge clk);
    idle();
    #1 check("md2_wait0", {26'd0, outs}, {26'd0, OMd});
    @(negedge clk);
    rst = 1'b1;
    #1 check("md2_rst_outs", {26'd0, outs}, {26'd0, ONorm});
    @(negedge clk);
    rst = 1'b0;
    #1 check("md2_after_rst", {26'd0, outs}, {26'd0, ONorm});
    check("md2_stall_cnt", stall_cnt, 32'd0);
    check("md2_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    #1 check("md2_run_stays", {26'd0, outs}, {26'd0, ONorm});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
